// File: rtl/imhotep_pkg.sv
// Shared core parameters and the types used by the load/store unit.
package imhotep_pkg;

    localparam int XLEN      = 32;
    localparam int RAM_WIDTH = 10;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_funct3_e;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        NONE = 2'b11
    } mem_width_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage and the load/store unit.
interface lsu_if;

    logic                         req_valid_i;
    logic                         req_ready_o;
    logic                         req_we_i;
    logic [2:0]                   req_funct3_i;
    logic [imhotep_pkg::XLEN-1:0] req_addr_i;
    logic [imhotep_pkg::XLEN-1:0] req_wdata_i;

    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [imhotep_pkg::XLEN-1:0] rsp_rdata_o;
    logic                         rsp_err_o;

    // Pipeline side: issues requests, consumes responses.
    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    // Load/store unit side.
    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/lsu_extend.sv
// Load data extension: picks the access-sized field of the raw RAM word and
// sign- or zero-extends it according to funct3.
module lsu_extend
    import imhotep_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] ext
);

    // Extension select; unknown codes yield zero.
    always_comb begin
        ext = '0;
        case (funct3)
            LB:      ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
            LH:      ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
            LW:      ext = raw;
            LBU:     ext = {{(XLEN-8){1'b0}}, raw[7:0]};
            LHU:     ext = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, legality check, a single RAM
// access cycle, then a held response until the pipeline accepts it.
//
// state  | meaning
// IDLE   | ready for a request; RAM port parked (width NONE)
// ACCESS | one cycle driving the RAM; store commits / load captured at its end
// RESP   | response valid and held until rsp_ready_i
module lsu
    import imhotep_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    lsu_if.slave                 bus,
    output logic                 ram_w_rn_o,
    output logic [1:0]           ram_width_o,
    output logic [RAM_WIDTH-1:0] ram_addr_o,
    output logic [XLEN-1:0]      ram_data_o,
    input  logic [XLEN-1:0]      ram_data_i
);

    lsu_state_e           state_q;
    lsu_state_e           state_d;

    logic                 we_q;
    logic [2:0]           funct3_q;
    logic [RAM_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]      wdata_q;
    logic [XLEN-1:0]      rdata_q;
    logic                 err_q;

    logic                 funct3_bad;
    logic                 range_bad;
    logic                 misaligned;
    logic                 illegal;
    logic                 accept;
    logic                 rsp_done;
    logic [XLEN-1:0]      load_ext;

    lsu_extend u_extend (
        .funct3 (funct3_q),
        .raw    (ram_data_i),
        .ext    (load_ext)
    );

    // Legality of the request currently offered on the bus.
    always_comb begin
        funct3_bad = 1'b0;
        if (bus.req_we_i) begin
            funct3_bad = !(bus.req_funct3_i inside {LB, LH, LW});
        end else begin
            funct3_bad = !(bus.req_funct3_i inside {LB, LH, LW, LBU, LHU});
        end
        range_bad  = |bus.req_addr_i[XLEN-1:RAM_WIDTH];
        misaligned = ((bus.req_funct3_i[1:0] == HALF) && bus.req_addr_i[0]) ||
                     ((bus.req_funct3_i[1:0] == WORD) && (bus.req_addr_i[1:0] != 2'b00));
        illegal    = funct3_bad || range_bad || (CHECK_ALIGN && misaligned);
    end

    // Next state, handshake outputs and the RAM port drive.
    always_comb begin
        state_d         = state_q;
        bus.req_ready_o = 1'b0;
        bus.rsp_valid_o = 1'b0;
        ram_w_rn_o      = 1'b0;
        ram_width_o     = NONE;
        ram_addr_o      = '0;
        ram_data_o      = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    state_d = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                ram_w_rn_o  = we_q;
                ram_width_o = funct3_q[1:0];
                ram_addr_o  = addr_q;
                ram_data_o  = wdata_q;
                state_d     = RESP;
            end
            RESP: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept   = (state_q == IDLE) && bus.req_valid_i;
    assign rsp_done = (state_q == RESP) && bus.rsp_ready_i;

    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on accept; response data captured at the end of ACCESS
    // and cleared once the response has been taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= bus.req_we_i;
            funct3_q <= bus.req_funct3_i;
            addr_q   <= bus.req_addr_i[RAM_WIDTH-1:0];
            wdata_q  <= bus.req_wdata_i;
            rdata_q  <= '0;
            err_q    <= illegal;
        end else if (state_q == ACCESS) begin
            rdata_q  <= we_q ? '0 : load_ext;
        end else if (rsp_done) begin
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for the load/store unit: directed scenarios then random traffic,
// checked against a byte-array memory model and the legality rules.
module tb_lsu;
    import imhotep_pkg::*;

    localparam int RAM_BYTES = 1 << RAM_WIDTH;

    logic                 clk;
    logic                 reset_n;
    logic                 ram_w_rn;
    logic [1:0]           ram_width;
    logic [RAM_WIDTH-1:0] ram_addr;
    logic [XLEN-1:0]      ram_wdata;
    logic [XLEN-1:0]      ram_rdata;

    logic [7:0] ram_mem [RAM_BYTES];
    logic [7:0] ref_mem [RAM_BYTES];

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;

    lsu_if bus();

    lsu #(.CHECK_ALIGN(1'b1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .ram_w_rn_o  (ram_w_rn),
        .ram_width_o (ram_width),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_wdata),
        .ram_data_i  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simulation RAM: combinational read, write at the clock edge.
    always_comb begin
        ram_rdata = '0;
        if (ram_width != 2'b11) begin
            for (int k = 0; k < (1 << ram_width); k++) begin
                ram_rdata[8*k +: 8] = ram_mem[RAM_WIDTH'(ram_addr + RAM_WIDTH'(k))];
            end
        end
    end

    always @(posedge clk) begin
        if (ram_w_rn && ram_width != 2'b11) begin
            for (int k = 0; k < (1 << ram_width); k++) begin
                ram_mem[RAM_WIDTH'(ram_addr + RAM_WIDTH'(k))] <= ram_wdata[8*k +: 8];
            end
        end
    end

    // Count cycles in which the RAM port is active.
    always @(negedge clk) begin
        if (ram_width != 2'b11) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_illegal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        bit ok;
        int sz;
        if (we) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!ok) return 1'b1;
        if (addr >= 32'(RAM_BYTES)) return 1'b1;
        sz = 1 << f3[1:0];
        if ((addr % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] raw;
        raw = 32'h0;
        for (int k = 0; k < (1 << f3[1:0]); k++) begin
            raw[8*k +: 8] = ref_mem[(addr + k) % RAM_BYTES];
        end
        case (f3)
            3'd0:    return {{24{raw[7]}}, raw[7:0]};
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd4:    return {24'h0, raw[7:0]};
            3'd5:    return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        for (int k = 0; k < (1 << f3[1:0]); k++) begin
            ref_mem[(addr + k) % RAM_BYTES] = wdata[8*k +: 8];
        end
    endtask

    // One full transaction, response held off for 'hold' cycles.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        bit          bad;
        logic [31:0] exp;
        int          a0;
        a0  = acc_cnt;
        bad = ref_illegal(we, f3, addr);
        exp = 32'h0;
        chk("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        tick();
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = $urandom;
        bus.req_wdata_i  = $urandom;
        if (bad) begin
            chk("err_valid", 32'(bus.rsp_valid_o), 32'd1);
            chk("err_flag", 32'(bus.rsp_err_o), 32'd1);
            chk("err_rdata", bus.rsp_rdata_o, 32'h0);
        end else begin
            chk("acc_valid_low", 32'(bus.rsp_valid_o), 32'd0);
            chk("acc_width", 32'(ram_width), 32'(f3[1:0]));
            chk("acc_w_rn", 32'(ram_w_rn), 32'(we));
            chk("acc_addr", 32'(ram_addr), addr % RAM_BYTES);
            chk("acc_data", ram_wdata, wdata);
            tick();
            if (we) ref_store(f3, addr, wdata);
            else    exp = ref_load(f3, addr);
            chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
            chk("rsp_err", 32'(bus.rsp_err_o), 32'd0);
            chk("rsp_rdata", bus.rsp_rdata_o, exp);
        end
        chk("req_ready_busy", 32'(bus.req_ready_o), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
            chk("hold_rdata", bus.rsp_rdata_o, exp);
            chk("hold_ready", 32'(bus.req_ready_o), 32'd0);
            chk("hold_width", 32'(ram_width), 32'd3);
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        chk("done_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("done_ready", 32'(bus.req_ready_o), 32'd1);
        chk("acc_cycles", 32'(acc_cnt - a0), bad ? 32'd0 : 32'd1);
    endtask

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          sel;

        for (int i = 0; i < RAM_BYTES; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'd0;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;
        bus.rsp_ready_i  = 1'b0;
        reset_n          = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rst_err", 32'(bus.rsp_err_o), 32'd0);
        chk("rst_width", 32'(ram_width), 32'd3);
        chk("rst_w_rn", 32'(ram_w_rn), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
        do_req(1'b1, 3'b000, 32'h21, 32'h00000080, 1);
        do_req(1'b0, 3'b000, 32'h21, 32'h0, 0);
        do_req(1'b0, 3'b100, 32'h21, 32'h0, 0);
        do_req(1'b0, 3'b001, 32'h20, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h03, 32'h1234, 0);
        do_req(1'b0, 3'b010, 32'h00, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'(RAM_BYTES), 32'h0, 0);
        do_req(1'b0, 3'b011, 32'h00, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5);

        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b010;
        bus.req_addr_i   = 32'h10;
        tick();
        bus.req_valid_i  = 1'b0;
        tick();
        chk("rstmid_pre_valid", 32'(bus.rsp_valid_o), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rstmid_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rstmid_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rstmid_width", 32'(ram_width), 32'd3);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            we  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 15);
            if (sel == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            addr = 32'($urandom_range(0, 63));
            sel  = $urandom_range(0, 15);
            if (sel == 0) addr = 32'(RAM_BYTES) + 32'($urandom_range(0, 4095));
            else if (sel > 3) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            do_req(we, f3, addr, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
